// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared op encodings, bus widths and FSM state type for the memory stage.
package mem_ctrl_pkg;
    localparam int RegBus = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus = 8;
    localparam logic [RegBus-1:0] ZeroWord = '0;
    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [AluOpBus-1:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b11101011;
    typedef enum logic {IDLE, BUS} state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: big-endian lane select, store replication and load extract/extension.
module mem_align
    import mem_ctrl_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          off,
    input  logic [RegBus-1:0]   sdata,
    input  logic [RegBus-1:0]   rdata,
    output logic                is_mem,
    output logic                is_load,
    output logic                misalign,
    output logic [3:0]          sel,
    output logic [RegBus-1:0]   wdata,
    output logic [RegBus-1:0]   ldata
);
    logic is_byte, is_half, is_word;
    logic [7:0] b;
    logic [15:0] h;
    assign is_byte = aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
    assign is_half = aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    assign is_word = aluop inside {EXE_LW_OP, EXE_SW_OP};
    assign is_load = aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    assign is_mem = is_byte | is_half | is_word;
    assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
    assign sel = is_byte ? (4'b1000 >> off) : is_half ? (off[1] ? 4'b0011 : 4'b1100) :
                 is_word ? 4'b1111 : 4'b0000;
    assign wdata = is_byte ? {4{sdata[7:0]}} : is_half ? {2{sdata[15:0]}} : sdata;
    // byte offset 0 sits in bits 31:24, so shift right by 8*(3-off)
    assign b = 8'(rdata >> {~off, 3'b000});
    assign h = off[1] ? rdata[15:0] : rdata[31:16];
    assign ldata = aluop == EXE_LB_OP  ? {{24{b[7]}}, b} :
                   aluop == EXE_LBU_OP ? {24'b0, b} :
                   aluop == EXE_LH_OP  ? {{16{h[15]}}, h} :
                   aluop == EXE_LHU_OP ? {16'b0, h} :
                   aluop == EXE_LW_OP  ? rdata : ZeroWord;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM pipeline stage driving a req/ack data bus with alignment checks and timeout.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd_i,
    input  logic                  ex_wreg_i,
    input  logic [RegBus-1:0]     ex_wdata_i,
    input  logic [AluOpBus-1:0]   ex_aluop_i,
    input  logic [RegBus-1:0]     ex_mem_addr_i,
    input  logic [RegBus-1:0]     ex_mem_data_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [RegBus-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [RegBus-1:0]     bus_wdata_o,
    input  logic [RegBus-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [RegAddrBus-1:0] wb_wd_o,
    output logic                  wb_wreg_o,
    output logic [RegBus-1:0]     wb_wdata_o,
    output logic                  stallreq_o,
    output logic                  exc_align_o,
    output logic                  bus_err_o
);
    state_t state;
    logic [7:0] cnt;
    logic [RegAddrBus-1:0] sv_wd;
    logic sv_wreg;
    logic [AluOpBus-1:0] sv_op;
    logic [1:0] sv_off;
    logic is_mem, is_load, misalign, timeout_hit;
    logic [3:0] sel;
    logic [RegBus-1:0] wdata, ldata;
    // in BUS the aligner decodes the captured op so the load can be extracted on ack
    mem_align u_align (
        .aluop   (state == IDLE ? ex_aluop_i : sv_op),
        .off     (state == IDLE ? ex_mem_addr_i[1:0] : sv_off),
        .sdata   (ex_mem_data_i),
        .rdata   (bus_rdata_i),
        .is_mem  (is_mem),
        .is_load (is_load),
        .misalign(misalign),
        .sel     (sel),
        .wdata   (wdata),
        .ldata   (ldata)
    );
    assign timeout_hit = cnt == 8'(TIMEOUT - 1);
    assign stallreq_o = rst ? 1'b0 : state == IDLE ? is_mem & ~misalign : ~bus_ack_i & ~timeout_hit;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus_req_o <= 1'b0;
            bus_we_o <= 1'b0;
            bus_addr_o <= ZeroWord;
            bus_sel_o <= 4'b0000;
            bus_wdata_o <= ZeroWord;
            wb_wd_o <= '0;
            wb_wreg_o <= 1'b0;
            wb_wdata_o <= ZeroWord;
            exc_align_o <= 1'b0;
            bus_err_o <= 1'b0;
            sv_wd <= '0;
            sv_wreg <= 1'b0;
            sv_op <= EXE_NOP_OP;
            sv_off <= 2'b00;
        end else begin
            exc_align_o <= 1'b0;
            bus_err_o <= 1'b0;
            wb_wreg_o <= 1'b0;
            if (state == IDLE) begin
                if (!is_mem) begin
                    wb_wd_o <= ex_wd_i;
                    wb_wreg_o <= ex_wreg_i;
                    wb_wdata_o <= ex_wdata_i;
                end else if (misalign) begin
                    exc_align_o <= 1'b1;
                end else begin
                    state <= BUS;
                    cnt <= '0;
                    bus_req_o <= 1'b1;
                    bus_we_o <= ~is_load;
                    bus_addr_o <= {ex_mem_addr_i[31:2], 2'b00};
                    bus_sel_o <= sel;
                    bus_wdata_o <= wdata;
                    sv_wd <= ex_wd_i;
                    sv_wreg <= ex_wreg_i;
                    sv_op <= ex_aluop_i;
                    sv_off <= ex_mem_addr_i[1:0];
                end
            end else if (bus_ack_i) begin
                state <= IDLE;
                bus_req_o <= 1'b0;
                bus_we_o <= 1'b0;
                wb_wd_o <= sv_wd;
                wb_wreg_o <= is_load & sv_wreg;
                wb_wdata_o <= ldata;
            end else if (timeout_hit) begin
                state <= IDLE;
                bus_req_o <= 1'b0;
                bus_we_o <= 1'b0;
                bus_err_o <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors with hand-computed expectations for mem_ctrl (TIMEOUT=4).
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] ex_wd = '0;
    logic ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_addr = '0, ex_data = '0, bus_rdata = '0;
    logic [7:0] ex_op = EXE_NOP_OP;
    logic bus_ack = 1'b0;
    logic bus_req, bus_we, wb_wreg, stallreq, exc_align, bus_err;
    logic [31:0] bus_addr, bus_wdata, wb_wdata;
    logic [3:0] bus_sel;
    logic [4:0] wb_wd;
    int checks = 0, failures = 0;
    int stalls, req_cycles;
    logic [31:0] o_addr, o_wdata;
    logic [3:0] o_sel;
    logic o_we;

    mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata),
        .ex_aluop_i(ex_op), .ex_mem_addr_i(ex_addr), .ex_mem_data_i(ex_data),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata), .stallreq_o(stallreq),
        .exc_align_o(exc_align), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] sdata);
        ex_op = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_addr = addr; ex_data = sdata;
    endtask

    task automatic nop();
        set_op(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // aligned access acked after `waits` BUS cycles; leaves a nop on EX afterwards
    task automatic access(input logic [7:0] op, input logic [4:0] wd, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits);
        set_op(op, wd, 1'b1, 32'h0, addr, sdata);
        bus_rdata = rdata; bus_ack = 1'b0; stalls = 0; req_cycles = 0;
        #1 stalls += int'(stallreq);
        tick();
        o_addr = bus_addr; o_sel = bus_sel; o_we = bus_we; o_wdata = bus_wdata;
        for (int i = 0; i < waits; i++) begin
            stalls += int'(stallreq); req_cycles += int'(bus_req);
            tick();
        end
        bus_ack = 1'b1;
        #1 stalls += int'(stallreq); req_cycles += int'(bus_req);
        tick();
        bus_ack = 1'b0;
        nop();
    endtask

    initial begin
        set_op(EXE_LW_OP, 5'd1, 1'b1, 32'h0, 32'h100, 32'h0);
        tick();
        check("rst_stall", {31'b0, stallreq}, 32'h0);
        tick();
        check("rst_req", {31'b0, bus_req}, 32'h0);
        check("rst_wreg", {31'b0, wb_wreg}, 32'h0);
        check("rst_wdata", wb_wdata, 32'h0);
        check("rst_sel", {28'b0, bus_sel}, 32'h0);
        rst = 1'b0;
        set_op(EXE_OR_OP, 5'd5, 1'b1, 32'h0000F0F0, 32'h0, 32'h0);
        #1 check("or_stall", {31'b0, stallreq}, 32'h0);
        tick();
        check("or_wdata", wb_wdata, 32'h0000F0F0);
        check("or_wd", {27'b0, wb_wd}, 32'd5);
        check("or_wreg", {31'b0, wb_wreg}, 32'h1);

        access(EXE_LB_OP, 5'd3, 32'h103, 32'h0, 32'h112233F4, 0);
        check("lb_sel", {28'b0, o_sel}, 32'h1);
        check("lb_addr", o_addr, 32'h100);
        check("lb_we", {31'b0, o_we}, 32'h0);
        check("lb_data", wb_wdata, 32'hFFFFFFF4);
        check("lb_wreg", {31'b0, wb_wreg}, 32'h1);
        check("lb_wd", {27'b0, wb_wd}, 32'd3);
        check("lb_stalls", stalls, 1);
        check("lb_req_done", {31'b0, bus_req}, 32'h0);
        access(EXE_LBU_OP, 5'd4, 32'h103, 32'h0, 32'h112233F4, 0);
        check("lbu_data", wb_wdata, 32'h000000F4);

        access(EXE_SH_OP, 5'd7, 32'h202, 32'h0000ABCD, 32'h0, 3);
        check("sh_sel", {28'b0, o_sel}, 32'h3);
        check("sh_wdata", o_wdata, 32'hABCDABCD);
        check("sh_we", {31'b0, o_we}, 32'h1);
        check("sh_addr", o_addr, 32'h200);
        check("sh_stalls", stalls, 4);
        check("sh_req_cycles", req_cycles, 4);
        check("sh_wreg", {31'b0, wb_wreg}, 32'h0);

        access(EXE_SB_OP, 5'd1, 32'h301, 32'h0000015A, 32'h0, 1);
        check("sb_sel", {28'b0, o_sel}, 32'h4);
        check("sb_wdata", o_wdata, 32'h5A5A5A5A);
        access(EXE_LH_OP, 5'd2, 32'h200, 32'h0, 32'h80011234, 0);
        check("lh_data", wb_wdata, 32'hFFFF8001);
        access(EXE_LHU_OP, 5'd2, 32'h202, 32'h0, 32'h1234ABCD, 2);
        check("lhu_data", wb_wdata, 32'h0000ABCD);
        access(EXE_LW_OP, 5'd9, 32'h104, 32'h0, 32'hDEADBEEF, 0);
        check("lw_data", wb_wdata, 32'hDEADBEEF);
        check("lw_sel", {28'b0, o_sel}, 32'hF);

        set_op(EXE_LW_OP, 5'd6, 1'b1, 32'h0, 32'h101, 32'h0);
        #1 check("mis_stall", {31'b0, stallreq}, 32'h0);
        tick();
        check("mis_req", {31'b0, bus_req}, 32'h0);
        check("mis_exc", {31'b0, exc_align}, 32'h1);
        check("mis_wreg", {31'b0, wb_wreg}, 32'h0);
        nop();
        tick();
        check("mis_exc_pulse", {31'b0, exc_align}, 32'h0);

        set_op(EXE_OR_OP, 5'd8, 1'b1, 32'h00000042, 32'h0, 32'h0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("ack_idle_req", {31'b0, bus_req}, 32'h0);
        check("ack_idle_wdata", wb_wdata, 32'h00000042);

        set_op(EXE_LW_OP, 5'd6, 1'b1, 32'h0, 32'h300, 32'h0);
        tick();
        stalls = 0; req_cycles = 0;
        for (int i = 0; i < 8 && bus_req; i++) begin
            req_cycles++;
            if (i < 3) stalls += int'(stallreq);
            else check("to_final_stall", {31'b0, stallreq}, 32'h0);
            tick();
        end
        check("to_req_cycles", req_cycles, 4);
        check("to_stalls", stalls, 3);
        check("to_err", {31'b0, bus_err}, 32'h1);
        check("to_wreg", {31'b0, wb_wreg}, 32'h0);
        nop();
        tick();
        check("to_err_pulse", {31'b0, bus_err}, 32'h0);
        check("to_idle_passthru", {31'b0, stallreq}, 32'h0);

        set_op(EXE_OR_OP, 5'd10, 1'b1, 32'h0000AAAA, 32'h0, 32'h0);
        tick();
        set_op(EXE_LW_OP, 5'd11, 1'b1, 32'h0, 32'h400, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1 check("rst_bus_stall", {31'b0, stallreq}, 32'h0);
        tick();
        check("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_bus_wdata", wb_wdata, 32'h0);
        check("rst_bus_wd", {27'b0, wb_wd}, 32'h0);
        rst = 1'b0;
        nop();
        tick();
        access(EXE_LW_OP, 5'd12, 32'h404, 32'h0, 32'hCAFEF00D, 1);
        check("post_rst_lw", wb_wdata, 32'hCAFEF00D);
        check("post_rst_wd", {27'b0, wb_wd}, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, bus cycles to wait for bus_ack_i before aborting an access (range 1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_wd_i  in  5  destination register address from EX.
REQ-005 ex_wreg_i  in  1  register write enable from EX.
REQ-006 ex_wdata_i  in  32  ALU result from EX.
REQ-007 ex_aluop_i  in  8  operation code, from the shared op encoding.
REQ-008 ex_mem_addr_i  in  32  effective byte address for load/store.
REQ-009 ex_mem_data_i  in  32  store data, right-justified.
REQ-010 bus_req_o, bus_we_o  out  1 each  bus request; write strobe.
REQ-011 bus_addr_o  out  32  word address, low two bits zero.
REQ-012 bus_sel_o  out  4  byte-lane select, bit 3 = bits 31:24.
REQ-013 bus_wdata_o  out  32; bus_rdata_i  in  32; bus_ack_i  in  1.
REQ-014 wb_wd_o  out  5; wb_wreg_o  out  1; wb_wdata_o  out  32  registered results to WB.
REQ-015 stallreq_o  out  1  combinational pipeline stall request.
REQ-016 exc_align_o, bus_err_o  out  1 each  one-cycle error pulses.

Function
REQ-017 Memory ops SHALL be LB, LBU, LH, LHU, LW, SB, SH, SW; every other aluop is a pass-through op.
REQ-018 Pass-through op: wb_* SHALL load ex_wd_i/ex_wreg_i/ex_wdata_i at the next edge, 1-cycle latency, stallreq_o=0.
REQ-019 FSM states IDLE, BUS; only IDLE accepts new ops.
REQ-020 IDLE plus aligned memory op: stallreq_o=1, go to BUS at next edge with registered bus_req_o=1 and addr/sel/we/wdata; wb_wreg_o=0 (bubble) that edge.
REQ-021 BUS: bus outputs held stable; stallreq_o = NOT bus_ack_i; wb_wreg_o=0 each edge without ack.
REQ-022 BUS with bus_ack_i=1: at that edge go to IDLE, bus_req_o=0, wb_* written (loads: extracted data, wreg as given; stores: wb_wreg_o=0). Minimum memory-op latency 2 cycles.
REQ-023 Byte order big-endian: byte at addr[1:0]=0 occupies bits 31:24; halfword at addr[1]=0 occupies bits 31:16.
REQ-024 Byte/half lanes: SB/LB sel one-hot per addr[1:0]; SH/LH sel 1100 or 0011; word sel 1111; store data replicated across all lanes.
REQ-025 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
REQ-026 Misaligned half (addr[0]=1) or word (addr[1:0]!=0): no bus request, exc_align_o pulses for one cycle at the next edge, wb_wreg_o=0, no stall.
REQ-027 8-bit wait counter clears on entering BUS; if TIMEOUT cycles elapse without ack, go to IDLE, drop bus_req_o, pulse bus_err_o, wb_wreg_o=0, stallreq_o=0 in the final cycle.
REQ-028 bus_ack_i outside BUS SHALL be ignored.

Reset
REQ-029 rst at any edge: state IDLE, counter 0, bus_req_o=0, bus_we_o=0, bus_addr_o/bus_wdata_o=0, bus_sel_o=0, wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0, error pulses 0; an in-flight access is abandoned.
REQ-030 While rst=1, stallreq_o SHALL be 0.

Structure
REQ-031 Op codes, width constants (RegBus, RegAddrBus, AluOpBus) and ZeroWord live in the shared defines package; no local op encodings.
REQ-032 One sub-module, mem_align: combinational lane-select, store-replication and load-extract/extension logic.

Verification
REQ-033 OR result 0x0000F0F0 to r5 -> wb_wdata_o=0x0000F0F0, wb_wd_o=5, wb_wreg_o=1 next edge, no stall.
REQ-034 LB addr 0x103, mem word 0x112233F4, ack first BUS cycle -> wb_wdata_o=0xFFFFFFF4 after 2 cycles; LBU same -> 0x000000F4.
REQ-035 SH addr 0x202 data 0xABCD, ack after 3 waits -> bus_sel_o=0011, bus_wdata_o=0xABCDABCD, stallreq_o high 4 cycles, wb_wreg_o=0.
REQ-036 LW addr 0x101 -> no bus_req_o, exc_align_o one pulse, wb_wreg_o=0.
REQ-037 LW with no ack, TIMEOUT=4 -> bus_req_o high 4 cycles, bus_err_o pulse, FSM IDLE.
REQ-038 rst asserted in 2nd BUS cycle -> bus_req_o=0 and all wb_* zero at that edge; next op accepted normally.
